// File: rtl/sr_window_pkg.sv
// Shared types and helpers for the reference-pixel window buffer.
package sr_window_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

    // LSB position of pixel k inside a packed row of dw-bit pixels.
    function automatic int unsigned pix_lsb(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/sr_row_reg.sv
// One row of the window: a W-bit register with async reset and load enable.
module sr_row_reg #(
    parameter int unsigned W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sr_window_param.sv
// Reference-pixel window: shifts in ROWS rows, then streams adjacent row pairs
// (row p, row p+1) to the interpolation filters, single-pass or circular.
module sr_window_param
    import sr_window_pkg::*;
#(
    parameter  int unsigned DATAWIDTH = 8,
    parameter  int unsigned PIXELS    = 8,
    parameter  int unsigned ROWS      = 8,
    localparam int unsigned CNT_W     = cnt_width(ROWS),
    localparam int unsigned ROW_W     = PIXELS * DATAWIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               enable_read,
    input  logic               mode_circ,
    input  logic               in_valid,
    input  logic [ROW_W-1:0]   in_row,
    output logic [2*ROW_W-1:0] out_pair,
    output logic               out_valid,
    output logic               full,
    output logic [CNT_W-1:0]   row_cnt,
    output logic               done
);

    localparam int unsigned PTR_W = $clog2(ROWS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2*ROW_W-1:0] out_pair_q, out_pair_d;
    logic               out_valid_q, out_valid_d;
    logic               full_q, full_d;
    logic               done_q, done_d;

    logic               shift_en;
    logic [PTR_W-1:0]   rd_hi;
    logic [ROW_W-1:0]   row_data [ROWS];
    logic [ROW_W-1:0]   row_in   [ROWS];

    // Row 0 is the oldest; a shift drops it and appends in_row at the top.
    for (genvar i = 0; i < int'(ROWS); i++) begin : g_row
        if (i == int'(ROWS) - 1) begin : g_top
            assign row_in[i] = in_row;
        end else begin : g_mid
            assign row_in[i] = row_data[i+1];
        end

        sr_row_reg #(
            .W(ROW_W)
        ) u_row (
            .clock(clock),
            .reset(reset),
            .load (shift_en),
            .d    (row_in[i]),
            .q    (row_data[i])
        );
    end

    assign rd_hi = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_pair_d  = out_pair_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;
        shift_en    = 1'b0;

        if (enable) begin
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_en  = 1'b1;
                        row_cnt_d = CNT_W'(1);
                        state_d   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A full window keeps sliding: oldest row drops, count stays saturated.
                    if (in_valid) begin
                        shift_en = 1'b1;
                        if (row_cnt_q != CNT_W'(ROWS)) begin
                            row_cnt_d = row_cnt_q + CNT_W'(1);
                        end
                    end
                    if (enable_read && full_q) begin
                        state_d  = S_READ;
                        rd_ptr_d = '0;
                    end
                end
                S_READ: begin
                    if (!enable_read) begin
                        state_d   = S_IDLE;
                        row_cnt_d = '0;
                        rd_ptr_d  = '0;
                    end else begin
                        out_pair_d  = {row_data[rd_hi], row_data[rd_ptr_q]};
                        out_valid_d = 1'b1;
                        if (rd_ptr_q == PTR_W'(ROWS - 2)) begin
                            rd_ptr_d = '0;
                            if (!mode_circ) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_d    = 1'b1;
                    row_cnt_d = '0;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        full_d = (row_cnt_d == CNT_W'(ROWS));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            out_pair_q  <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_pair_q  <= out_pair_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            done_q      <= done_d;
        end
    end

    assign out_pair  = out_pair_q;
    assign out_valid = out_valid_q;
    assign full      = full_q;
    assign row_cnt   = row_cnt_q;
    assign done      = done_q;

endmodule
